// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared definitions for the multi-cycle ALU.
//   - opcode constants (6-bit alufn encoding)
//   - FSM state type and state constants
//   - add_sub_ovf(): signed two's-complement overflow check for ADD/SUB
// Optional macro: ALU_MC_DIV_EN (enables opcode OP_DIV in the datapath).
package alu_mc_pkg;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_MUL = 6'b000010;
    localparam logic [5:0] OP_DIV = 6'b000011;
    localparam logic [5:0] OP_AND = 6'b000100;
    localparam logic [5:0] OP_OR  = 6'b000101;
    localparam logic [5:0] OP_XOR = 6'b000110;
    localparam logic [5:0] OP_SLL = 6'b001000;
    localparam logic [5:0] OP_SRL = 6'b001001;
    localparam logic [5:0] OP_SLT = 6'b001011;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Only the sign bits matter: ADD overflows when the operands agree in sign,
    // SUB when they differ, and in both cases the result sign differs from a.
    function automatic logic add_sub_ovf(input logic a_msb, input logic b_msb,
                                         input logic r_msb, input logic is_sub);
        logic same_sign;
        same_sign = (a_msb == b_msb);
        return (is_sub ? !same_sign : same_sign) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: shared iterative datapath for unsigned MUL (and DIV when enabled).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         load operands and begin iterating (ignored-safe only when idle)
//   div_i           select division (present only with ALU_MC_DIV_EN)
//   a_i, b_i        operands (MUL: a*b, DIV: a/b)
//   done_o          high while the finished result is waiting to be taken
//   lo_o, hi_o      low/high halves of the accumulator (product or {rem, quotient})
// Optional macro: ALU_MC_DIV_EN adds restoring division, one quotient bit per cycle.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_BPC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
`ifdef ALU_MC_DIV_EN
    input  logic             div_i,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CntW = $clog2(WIDTH) + 1;
    localparam int SumW = WIDTH + MUL_BPC;
    localparam logic [CntW-1:0] MulSteps = CntW'(WIDTH / MUL_BPC);

    // acc_q holds {upper, lower}: for MUL the lower half starts as the multiplier
    // and is shifted out as product bits shift in; for DIV it is {rem, dividend/quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               run_q, run_d;

    logic [MUL_BPC-1:0] digit;
    logic [SumW-1:0]    mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] step_next;

`ifdef ALU_MC_DIV_EN
    logic               div_q, div_d;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] div_next;
    localparam logic [CntW-1:0] DivSteps = CntW'(WIDTH);
`endif

    always_comb begin
        digit    = acc_q[MUL_BPC-1:0];
        // Upper half plus multiplicand*digit always fits in WIDTH+MUL_BPC bits.
        mul_sum  = SumW'(acc_q[2*WIDTH-1:WIDTH]) + SumW'(opb_q) * SumW'(digit);
        mul_next = {mul_sum, acc_q[WIDTH-1:MUL_BPC]};
        step_next = mul_next;
`ifdef ALU_MC_DIV_EN
        // Restoring step: shift {rem, q} left, try subtracting the divisor.
        // A zero divisor never borrows, so the quotient saturates to all ones.
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opb_q};
        div_next = {(rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0]),
                    acc_q[WIDTH-2:0], ~rem_diff[WIDTH]};
        if (div_q) begin
            step_next = div_next;
        end
`endif
    end

    always_comb begin
        acc_d = acc_q;
        opb_d = opb_q;
        cnt_d = cnt_q;
        run_d = run_q;
`ifdef ALU_MC_DIV_EN
        div_d = div_q;
`endif
        if (start_i) begin
            run_d = 1'b1;
`ifdef ALU_MC_DIV_EN
            div_d = div_i;
            if (div_i) begin
                acc_d = {{WIDTH{1'b0}}, a_i};
                opb_d = b_i;
                cnt_d = DivSteps;
            end else begin
                acc_d = {{WIDTH{1'b0}}, b_i};
                opb_d = a_i;
                cnt_d = MulSteps;
            end
`else
            acc_d = {{WIDTH{1'b0}}, b_i};
            opb_d = a_i;
            cnt_d = MulSteps;
`endif
        end else if (run_q) begin
            if (cnt_q != '0) begin
                acc_d = step_next;
                cnt_d = cnt_q - CntW'(1);
            end else begin
                // Result is taken by the parent on this edge.
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            opb_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
`ifdef ALU_MC_DIV_EN
            div_q <= 1'b0;
`endif
        end else begin
            acc_q <= acc_d;
            opb_q <= opb_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
`ifdef ALU_MC_DIV_EN
            div_q <= div_d;
`endif
        end
    end

    assign done_o = run_q && (cnt_q == '0);
    assign lo_o   = acc_q[WIDTH-1:0];
    assign hi_o   = acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes and registered results.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake; a, b, alufn sampled on acceptance
//   a, b, alufn           operands and 6-bit opcode
//   out_valid / out_ready result handshake; outputs held stable until taken
//   otp, zero             result and (otp == 0)
//   overflow, illegal     overflow flag, unsupported opcode flag
// Optional macro: ALU_MC_DIV_EN enables unsigned DIV (opcode 000011).
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_BPC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [5:0]       alufn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] otp,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int ShW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic             init_q;
    logic [WIDTH-1:0] otp_q, otp_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;

    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] sc_otp;
    logic             sc_ovf, sc_ill, is_multi, shamt_big, accept;
    logic             iter_done;
    logic [WIDTH-1:0] iter_lo, iter_hi;

`ifdef ALU_MC_DIV_EN
    logic is_div;
    logic div_q, div_d;
    logic divz_q, divz_d;
`endif

    // Single-cycle results come straight from the live inputs so they can be
    // registered on the acceptance edge.
    always_comb begin
        sum       = a + b;
        diff      = a - b;
        shamt_big = |b[WIDTH-1:ShW];
        sc_otp    = '0;
        sc_ovf    = 1'b0;
        sc_ill    = 1'b0;
        is_multi  = 1'b0;
        case (alufn)
            OP_ADD: begin
                sc_otp = sum;
                sc_ovf = add_sub_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1], 1'b0);
            end
            OP_SUB: begin
                sc_otp = diff;
                sc_ovf = add_sub_ovf(a[WIDTH-1], b[WIDTH-1], diff[WIDTH-1], 1'b1);
            end
            OP_MUL: is_multi = 1'b1;
`ifdef ALU_MC_DIV_EN
            OP_DIV: is_multi = 1'b1;
`endif
            OP_AND: sc_otp = a & b;
            OP_OR:  sc_otp = a | b;
            OP_XOR: sc_otp = a ^ b;
            OP_SLL: sc_otp = shamt_big ? '0 : (a << b[ShW-1:0]);
            OP_SRL: sc_otp = shamt_big ? '0 : (a >> b[ShW-1:0]);
            OP_SLT: sc_otp = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: sc_ill = 1'b1;
        endcase
    end

`ifdef ALU_MC_DIV_EN
    assign is_div = (alufn == OP_DIV);
`endif

    // init_q keeps in_ready low while reset is asserted and until the first edge.
    assign in_ready  = init_q && ((state_q == ST_IDLE) ||
                                  ((state_q == ST_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);

    alu_mc_iter #(
        .WIDTH   (WIDTH),
        .MUL_BPC (MUL_BPC)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (accept && is_multi),
`ifdef ALU_MC_DIV_EN
        .div_i   (is_div),
`endif
        .a_i     (a),
        .b_i     (b),
        .done_o  (iter_done),
        .lo_o    (iter_lo),
        .hi_o    (iter_hi)
    );

    always_comb begin
        state_d = state_q;
        otp_d   = otp_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
`ifdef ALU_MC_DIV_EN
        div_d   = div_q;
        divz_d  = divz_q;
`endif
        case (state_q)
            ST_BUSY: begin
                if (iter_done) begin
                    state_d = ST_DONE;
                    otp_d   = iter_lo;
                    zero_d  = (iter_lo == '0);
                    ill_d   = 1'b0;
                    ovf_d   = |iter_hi;
`ifdef ALU_MC_DIV_EN
                    if (div_q) begin
                        ovf_d = divz_q;
                    end
`endif
                end
            end
            ST_DONE: begin
                if (out_ready && !in_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = state_q;
        endcase

        if (accept) begin
            if (is_multi) begin
                state_d = ST_BUSY;
`ifdef ALU_MC_DIV_EN
                div_d   = is_div;
                divz_d  = (b == '0);
`endif
            end else begin
                state_d = ST_DONE;
                otp_d   = sc_otp;
                zero_d  = (sc_otp == '0);
                ovf_d   = sc_ovf;
                ill_d   = sc_ill;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            init_q  <= 1'b0;
            otp_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
`ifdef ALU_MC_DIV_EN
            div_q   <= 1'b0;
            divz_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            otp_q   <= otp_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
`ifdef ALU_MC_DIV_EN
            div_q   <= div_d;
            divz_q  <= divz_d;
`endif
        end
    end

    assign otp      = otp_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign illegal  = ill_q;

endmodule
